// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and types for the CORDIC stream front-end
package cordic_pkg;

  localparam int   DEFAULT_W = 16;
  localparam logic MODE_ROT  = 1'b0;
  localparam logic MODE_VEC  = 1'b1;

  typedef enum logic [2:0] {
    S_MODE,
    S_X,
    S_Y,
    S_Z,
    S_ISSUE
  } parse_state_t;

  typedef struct packed {
    logic [DEFAULT_W-1:0] res1;
    logic [DEFAULT_W-1:0] res2;
  } res_pair_t;

endpackage

// File: rtl/cordic_stream_frontend_if.sv
// rtl/cordic_stream_frontend_if.sv - valid/ready word stream used on both sides of the front-end
interface cordic_stream_frontend_if #(
  parameter int W = cordic_pkg::DEFAULT_W
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (output valid, data, last, input ready);
  // The command input has no framing, so the consumer side never looks at last.
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/cordic_result_fifo.sv
// rtl/cordic_result_fifo.sv - result-pair FIFO, first-word fall-through, modulo-DEPTH pointers
module cordic_result_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_push,
  input  logic [2*W-1:0] i_push_data,
  input  logic           i_pop,
  output logic [2*W-1:0] o_head,
  output logic           o_full,
  output logic           o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2*W-1:0] r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_pop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_head   = r_mem[r_rd_ptr];
  assign w_do_pop = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Credit accounting upstream should make this unreachable.
  assert property (@(posedge i_clk) disable iff (i_reset) !(i_push && o_full && !i_pop));

endmodule

// File: rtl/cordic_stream_frontend.sv
// rtl/cordic_stream_frontend.sv - parses mode/x/y[/z] words into CORDIC issues and
// serializes the fixed-latency result pairs back out as res1, res2
module cordic_stream_frontend
  import cordic_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int LAT   = 16,
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  cordic_stream_frontend_if.slave  i_in,
  cordic_stream_frontend_if.master o_out,
  output logic                    o_cmd_valid,
  output logic                    o_cmd_mode,
  output logic [W-1:0]            o_cmd_x,
  output logic [W-1:0]            o_cmd_y,
  output logic [W-1:0]            o_cmd_z,
  input  logic [W-1:0]            i_cordic_res1,
  input  logic [W-1:0]            i_cordic_res2
);
  localparam int CW = $clog2(DEPTH + 1);

  parse_state_t   r_state;
  logic           r_mode;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic [W-1:0]   r_z;
  logic [CW-1:0]  r_credits;
  logic [LAT-1:0] r_inflight;
  logic           r_phase;

  logic           w_in_fire;
  logic           w_issue;
  logic           w_out_valid;
  logic           w_out_fire;
  logic           w_release;
  logic           w_full;
  logic           w_empty;
  logic [2*W-1:0] w_head;

  assign i_in.ready = (r_state != S_ISSUE) && !i_reset;
  assign w_in_fire  = i_in.valid && i_in.ready;
  // Credits cover both in-flight and buffered pairs, so an issue always has a FIFO slot.
  assign w_issue    = (r_state == S_ISSUE) && (r_credits < CW'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_MODE;
      r_mode      <= MODE_ROT;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      o_cmd_valid <= 1'b0;
      o_cmd_mode  <= MODE_ROT;
      o_cmd_x     <= '0;
      o_cmd_y     <= '0;
      o_cmd_z     <= '0;
    end else begin
      o_cmd_valid <= 1'b0;
      case (r_state)
        S_MODE: if (w_in_fire) begin
          r_mode  <= i_in.data[0];
          r_state <= S_X;
        end
        S_X: if (w_in_fire) begin
          r_x     <= i_in.data;
          r_state <= S_Y;
        end
        S_Y: if (w_in_fire) begin
          r_y     <= i_in.data;
          r_state <= (r_mode == MODE_ROT) ? S_Z : S_ISSUE;
        end
        S_Z: if (w_in_fire) begin
          r_z     <= i_in.data;
          r_state <= S_ISSUE;
        end
        S_ISSUE: if (w_issue) begin
          o_cmd_valid <= 1'b1;
          o_cmd_mode  <= r_mode;
          o_cmd_x     <= r_x;
          o_cmd_y     <= r_y;
          o_cmd_z     <= (r_mode == MODE_VEC) ? '0 : r_z;
          r_state     <= S_MODE;
        end
        default: r_state <= S_MODE;
      endcase
    end
  end

  assign w_out_valid = !w_empty;
  assign w_out_fire  = w_out_valid && o_out.ready;
  assign w_release   = w_out_fire && r_phase;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_inflight <= '0;
      r_credits  <= '0;
      r_phase    <= 1'b0;
    end else begin
      r_inflight <= (r_inflight << 1) | LAT'(o_cmd_valid);
      case ({w_issue, w_release})
        2'b10:   r_credits <= r_credits + CW'(1);
        2'b01:   r_credits <= r_credits - CW'(1);
        default: r_credits <= r_credits;
      endcase
      if (w_out_fire) begin
        r_phase <= !r_phase;
      end
    end
  end

  // The head pair stays in the FIFO until its res2 word is taken, so stalls hold naturally.
  cordic_result_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (r_inflight[LAT-1]),
    .i_push_data ({i_cordic_res1, i_cordic_res2}),
    .i_pop       (w_release),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign o_out.valid = w_out_valid;
  assign o_out.data  = w_empty ? '0 : (r_phase ? w_head[W-1:0] : w_head[2*W-1:W]);
  assign o_out.last  = w_out_valid && r_phase;

endmodule

// File: tb/tb_cordic_stream_frontend.sv
// tb/tb_cordic_stream_frontend.sv - directed self-checking bench for cordic_stream_frontend
`timescale 1ns/1ps
module tb_cordic_stream_frontend;
  import cordic_pkg::*;

  localparam int W     = 16;
  localparam int LAT   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cordic_stream_frontend_if #(.W(W)) in_bus ();
  cordic_stream_frontend_if #(.W(W)) out_bus ();

  logic         cmd_valid, cmd_mode;
  logic [W-1:0] cmd_x, cmd_y, cmd_z;
  logic [W-1:0] res1, res2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;

  bit [LAT-1:0] pv = '0;
  int pk [LAT] = '{default: 0};
  res_pair_t core_pair;

  cordic_stream_frontend #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_in          (in_bus),
    .o_out         (out_bus),
    .o_cmd_valid   (cmd_valid),
    .o_cmd_mode    (cmd_mode),
    .o_cmd_x       (cmd_x),
    .o_cmd_y       (cmd_y),
    .o_cmd_z       (cmd_z),
    .i_cordic_res1 (res1),
    .i_cordic_res2 (res2)
  );

  // Core model: the k-th strobe returns 0x1111+k*0x100 / 0x2222+k*0x100, valid only at t+LAT.
  function automatic res_pair_t core_result(input int k);
    res_pair_t p;
    p.res1 = 16'h1111 + 16'(k * 256);
    p.res2 = 16'h2222 + 16'(k * 256);
    return p;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pv  <= {pv[LAT-2:0], cmd_valid === 1'b1};
    pk[0] <= strobe_cnt;
    for (int i = 1; i < LAT; i++) pk[i] <= pk[i-1];
    if (cmd_valid === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  assign core_pair = core_result(pk[LAT-1]);
  assign res1 = pv[LAT-1] ? core_pair.res1 : 16'hDEAD;
  assign res2 = pv[LAT-1] ? core_pair.res2 : 16'hBEEF;

  task automatic send_word(input logic [W-1:0] w);
    int n = 0;
    in_bus.valid = 1'b1;
    in_bus.data  = w;
    while (in_bus.ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL send_word_timeout in_ready=%b want 1", in_bus.ready);
    end
    @(negedge clk);
    in_bus.valid = 1'b0;
  endtask

  task automatic wait_strobe(output int tc);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    tc = cyc;
  endtask

  task automatic expect_word(input logic [W-1:0] d, input logic l, input string name);
    int n = 0;
    while (!(out_bus.valid === 1'b1 && out_bus.ready === 1'b1) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (out_bus.valid !== 1'b1 || out_bus.data !== d || out_bus.last !== l) begin
      errors++;
      $display("FAIL %s got valid=%b data=%h last=%b want data=%h last=%b",
               name, out_bus.valid, out_bus.data, out_bus.last, d, l);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_bus.valid = 1'b0; in_bus.data = '0; in_bus.last = 1'b0; out_bus.ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_bus.ready); end
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    checks++;
    if ({cmd_mode, cmd_x, cmd_y, cmd_z} !== '0) begin
      errors++; $display("FAIL reset_cmd_fields got %b %h %h %h want 0", cmd_mode, cmd_x, cmd_y, cmd_z);
    end
    checks++;
    if (out_bus.valid !== 1'b0 || out_bus.data !== '0 || out_bus.last !== 1'b0) begin
      errors++; $display("FAIL reset_out got %b %h %b want 0 0 0", out_bus.valid, out_bus.data, out_bus.last);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_bus.ready); end
  endtask

  task automatic test_rotation();
    int tc, tv, n;
    send_word(16'h0000); send_word(16'h4DBA); send_word(16'h0000);
    checks++;
    if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL rot_wait_z in_ready=%b want 1", in_bus.ready); end
    send_word(16'h2000);
    checks++;
    if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL rot_issue_ready got %b want 0", in_bus.ready); end
    wait_strobe(tc);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_mode !== 1'b0 || cmd_x !== 16'h4DBA || cmd_y !== 16'h0000 || cmd_z !== 16'h2000) begin
      errors++; $display("FAIL rot_cmd got v=%b m=%b x=%h y=%h z=%h want 1 0 4dba 0000 2000",
                         cmd_valid, cmd_mode, cmd_x, cmd_y, cmd_z);
    end
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rot_strobe_width got %b want 0", cmd_valid); end
    n = 0;
    while (out_bus.valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    tv = cyc;
    checks++;
    if (tv - tc != LAT + 1) begin errors++; $display("FAIL rot_latency got %0d want %0d", tv - tc, LAT + 1); end
    expect_word(16'h1111, 1'b0, "rot_res1");
    expect_word(16'h2222, 1'b1, "rot_res2");
    checks++;
    if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL rot_drain out_valid=%b want 0", out_bus.valid); end
  endtask

  task automatic test_vectoring();
    int tc;
    send_word(16'h0001); send_word(16'h3000); send_word(16'h4000);
    checks++;
    if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL vec_issue_ready got %b want 0", in_bus.ready); end
    wait_strobe(tc);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_mode !== 1'b1 || cmd_x !== 16'h3000 || cmd_y !== 16'h4000 || cmd_z !== 16'h0000) begin
      errors++; $display("FAIL vec_cmd got v=%b m=%b x=%h y=%h z=%h want 1 1 3000 4000 0000",
                         cmd_valid, cmd_mode, cmd_x, cmd_y, cmd_z);
    end
    @(negedge clk);
    checks++;
    if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL vec_next_mode_ready got %b want 1", in_bus.ready); end
    expect_word(16'h1211, 1'b0, "vec_res1");
    expect_word(16'h2322, 1'b1, "vec_res2");
  endtask

  task automatic test_mode_upper_bits();
    int tc;
    send_word(16'hFFFE); send_word(16'h1234); send_word(16'h5678);
    checks++;
    if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL mode_fffe_wait_z in_ready=%b want 1", in_bus.ready); end
    send_word(16'h0ABC);
    wait_strobe(tc);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_mode !== 1'b0 || cmd_x !== 16'h1234 || cmd_y !== 16'h5678 || cmd_z !== 16'h0ABC) begin
      errors++; $display("FAIL mode_fffe_cmd got v=%b m=%b x=%h y=%h z=%h want 1 0 1234 5678 0abc",
                         cmd_valid, cmd_mode, cmd_x, cmd_y, cmd_z);
    end
    expect_word(16'h1311, 1'b0, "mode_fffe_res1");
    expect_word(16'h2422, 1'b1, "mode_fffe_res2");
  endtask

  task automatic test_backpressure();
    int base;
    res_pair_t p;
    base = strobe_cnt;
    out_bus.ready = 1'b0;
    fork
      begin
        for (int c = 0; c < 6; c++) begin
          send_word(16'h0001); send_word(16'h0100 + 16'(c)); send_word(16'h0200 + 16'(c));
        end
      end
    join_none
    repeat (80) @(negedge clk);
    checks++;
    if (strobe_cnt - base != DEPTH) begin errors++; $display("FAIL bp_strobes got %0d want %0d", strobe_cnt - base, DEPTH); end
    checks++;
    if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_bus.ready); end
    checks++;
    if (out_bus.valid !== 1'b1 || out_bus.data !== 16'h1411 || out_bus.last !== 1'b0) begin
      errors++; $display("FAIL bp_head_hold got %b %h %b want 1 1411 0", out_bus.valid, out_bus.data, out_bus.last);
    end
    out_bus.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p = core_result(base + i);
      expect_word(p.res1, 1'b0, "bp_res1");
      expect_word(p.res2, 1'b1, "bp_res2");
    end
    checks++;
    if (strobe_cnt - base != 6) begin errors++; $display("FAIL bp_total_strobes got %0d want 6", strobe_cnt - base); end
  endtask

  task automatic test_ready_toggle();
    int base, got, n;
    logic pv_s, pr_s, pl_s;
    logic [W-1:0] pd_s;
    res_pair_t p;
    base = strobe_cnt; got = 0; n = 0;
    pv_s = 1'b0; pr_s = 1'b1; pl_s = 1'b0; pd_s = '0;
    fork
      begin
        for (int c = 0; c < 3; c++) begin
          send_word(16'h0000); send_word(16'h0A00 + 16'(c));
          send_word(16'h0B00 + 16'(c)); send_word(16'h0C00 + 16'(c));
        end
      end
    join_none
    while (got < 6 && n < 400) begin
      @(negedge clk); n++;
      if (pv_s && !pr_s) begin
        checks++;
        if (out_bus.valid !== 1'b1 || out_bus.data !== pd_s || out_bus.last !== pl_s) begin
          errors++; $display("FAIL toggle_hold got %b %h %b want 1 %h %b",
                             out_bus.valid, out_bus.data, out_bus.last, pd_s, pl_s);
        end
      end
      out_bus.ready = n[0];
      if (out_bus.valid === 1'b1 && out_bus.ready === 1'b1) begin
        p = core_result(base + got / 2);
        checks++;
        if (out_bus.data !== (got[0] ? p.res2 : p.res1) || out_bus.last !== got[0]) begin
          errors++; $display("FAIL toggle_word%0d got %h %b want %h %b", got, out_bus.data, out_bus.last,
                             got[0] ? p.res2 : p.res1, got[0]);
        end
        got++;
      end
      pv_s = out_bus.valid; pr_s = out_bus.ready; pd_s = out_bus.data; pl_s = out_bus.last;
    end
    checks++;
    if (got != 6) begin errors++; $display("FAIL toggle_count got %0d want 6", got); end
    out_bus.ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base, tc, n_cmd, n_out;
    res_pair_t p;
    base = strobe_cnt; n_cmd = 0; n_out = 0;
    out_bus.ready = 1'b1;
    send_word(16'h0001); send_word(16'h0111); send_word(16'h0222);
    send_word(16'h0001); send_word(16'h0333); send_word(16'h0444);
    send_word(16'h0000); send_word(16'h1111);
    checks++;
    if (strobe_cnt - base != 2) begin errors++; $display("FAIL rstmid_inflight got %0d want 2", strobe_cnt - base); end
    reset = 1'b1;
    #1;
    checks++;
    if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b want 0", in_bus.ready); end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) n_cmd++;
      if (out_bus.valid === 1'b1) n_out++;
    end
    checks++;
    if (n_cmd != 0) begin errors++; $display("FAIL rstmid_no_strobe got %0d want 0", n_cmd); end
    checks++;
    if (n_out != 0) begin errors++; $display("FAIL rstmid_no_output got %0d want 0", n_out); end
    send_word(16'h0000); send_word(16'h0123); send_word(16'h0456); send_word(16'h0789);
    wait_strobe(tc);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_mode !== 1'b0 || cmd_x !== 16'h0123 || cmd_y !== 16'h0456 || cmd_z !== 16'h0789) begin
      errors++; $display("FAIL rstmid_cmd got v=%b m=%b x=%h y=%h z=%h want 1 0 0123 0456 0789",
                         cmd_valid, cmd_mode, cmd_x, cmd_y, cmd_z);
    end
    p = core_result(base + 2);
    expect_word(p.res1, 1'b0, "rstmid_res1");
    expect_word(p.res2, 1'b1, "rstmid_res2");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rotation();
    test_vectoring();
    test_mode_upper_bits();
    test_backpressure();
    test_ready_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_stream_frontend.md
Name: cordic_stream_frontend

Overview:
Hardware front-end that drives the CORDIC core from a 16-bit word stream and returns its results as a word stream. The input uses the same command format as our CORDIC stimulus files: a mode word, x, y, then z only when mode==0. The block parses commands, issues each operand set to the CORDIC core with a one-cycle strobe, and tracks fixed-latency results. Result pairs are buffered and serialized out as res1 then res2. It sits between a host/DMA word interface and the cordic instance.

Parameters:
W, 16, datapath width of stream words, operands and results
LAT, 16, CORDIC core latency in cycles from issue strobe to valid res1/res2 (>=1)
DEPTH, 4, result FIFO depth in result pairs; also the max outstanding commands (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid&&in_ready
in_data  in  W  input word (mode/x/y/z)
cmd_valid  out  1  one-cycle issue strobe to CORDIC
cmd_mode  out  1  0=rotation, 1=vectoring
cmd_x, cmd_y, cmd_z  out  W each  operands, held stable until next issue
cordic_res1, cordic_res2  in  W each  CORDIC outputs, valid LAT cycles after strobe
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts word
out_data  out  W  result word
out_last  out  1  1 on res2 word of a pair

Behaviour:
- Reset values: cmd_valid=0, cmd_mode=0, cmd_x/y/z=0, out_valid=0, out_data=0, out_last=0, FSM=S_MODE, FIFO empty, in-flight tags cleared, credit count=0. in_ready=0 while reset is high.
- Parser FSM: S_MODE -> S_X -> S_Y -> (mode==0 ? S_Z : S_ISSUE); S_Z -> S_ISSUE; S_ISSUE -> S_MODE. Each parse state advances only on an input handshake.
- Mode word: only in_data[0] is used; upper bits are ignored. Mode 1 forces cmd_z=0.
- in_ready = 1 in S_MODE/S_X/S_Y/S_Z, 0 in S_ISSUE.
- S_ISSUE: the block waits until credits < DEPTH, where credits = in-flight + FIFO entries. In the first such cycle it asserts cmd_valid for exactly one cycle, increments credits, and returns to S_MODE. A command therefore never issues without guaranteed FIFO space.
- Minimum command spacing: 4 cycles for vectoring, 5 for rotation.
- Latency: if cmd_valid is high in cycle t, res1/res2 are sampled at the end of cycle t+LAT into the FIFO. The earliest out_valid is cycle t+LAT+1 (FIFO empty, serializer idle).
- In-flight tracking: a LAT-bit shift register. Bit 0 is set by cmd_valid and bit LAT-1 triggers the FIFO push. Multiple commands can be in flight.
- Serializer: pops one FIFO pair and emits res1 (out_last=0) then res2 (out_last=1). A pop decrements credits on the res2 handshake.
  - While out_valid && !out_ready, out_data and out_last hold.
  - Back-to-back pairs can be emitted with no bubble.
- Simultaneous FIFO push and pop in one cycle is legal, including when the FIFO is full with a pop in progress. Occupancy stays unchanged.
- Simultaneous issue and credit release: the net credit count is unchanged and the issue proceeds.
- Pointer wrap-around is modulo DEPTH, and there is no overflow by construction. A push while full is an assertion failure.
- Reset mid-operation: partial commands are discarded, in-flight results are dropped, the FIFO is flushed, and a word mid-serialization is abandoned.
- Results appear strictly in issue order.

Decomposition:
- Package cordic_pkg holds:
  - W default
  - MODE_ROT=1'b0 and MODE_VEC=1'b1
  - the parser state typedef (S_MODE, S_X, S_Y, S_Z, S_ISSUE)
  - the result-pair struct {res1,res2}
- One sub-module, cordic_result_fifo: a synchronous FIFO of width 2W and depth DEPTH with push/pop/full/empty and sync active-high reset.

Test Plan:
- Rotation command, stream 0x0001? no: 0x0000, 0x4DBA, 0x0000, 0x2000 -> one cmd_valid pulse with mode=0, x=0x4DBA, y=0, z=0x2000. Bench model returns res1=0x1111, res2=0x2222 at LAT=16. Output must be 0x1111 (last=0) then 0x2222 (last=1), with out_valid first high exactly 17 cycles after the strobe.
- Vectoring command 0x0001, 0x3000, 0x4000 -> issue after 3 words with mode=1, z=0. Any fourth word is parsed as the next mode word.
- Mode word 0xFFFE -> treated as rotation (bit0=0), so 4 words are consumed.
- Hold out_ready=0 and send 6 vectoring commands with DEPTH=4 -> exactly 4 strobes, then in_ready stays low in S_ISSUE. Releasing out_ready yields 12 words in order with no loss, and the remaining 2 commands then issue.
- out_ready toggling 1/0 every cycle with a continuous command stream -> out_data stable during stalls and every res1/res2 pair delivered in issue order.
- reset pulsed for one cycle after x of a rotation command and with 2 results in flight -> no cmd_valid follows and no out_valid ever appears for dropped results. The next full command works normally.
